// File: rtl/obi_axi_bridge.sv
`default_nettype none
//==============================================================================
// Module   : obi_axi_bridge (with companion package obi_axi_pkg)
// Purpose  : Registered OBI-to-AXI4 manager bridge. Single-beat AXI requests
//            are issued straight from the held OBI request. AW and W complete
//            independently. An order FIFO of MAX_OUTSTANDING entries
//            (0 = read, 1 = write) steers R/B acceptance so that OBI sees
//            responses strictly in issue order.
// Ports    : clk_i, rst_ni          clock, asynchronous active-low reset
//            obi_req_i/obi_gnt_o    OBI address phase handshake
//            obi_we_i, obi_be_i,
//            obi_addr_i, obi_wdata_i  OBI request payload (stable until grant)
//            obi_rvalid_o, obi_rdata_o, obi_err_o  registered OBI response
//            axi_req_o / axi_resp_i AXI4 request / response structs
//            axi_id_i               static ID driven on AW and AR
// Option   : `define OBI_AXI_BRIDGE_ERR_EN to map AXI SLVERR/DECERR onto
//            obi_err_o. Without it obi_err_o is tied low.
// Revision : 1.0 - initial release
//==============================================================================

package obi_axi_pkg;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic        user;
    } axi_32_aw_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic        user;
    } axi_32_ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        user;
    } axi_32_w_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
        logic       user;
    } axi_32_b_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } axi_32_r_t;

    typedef struct packed {
        axi_32_aw_t aw;
        logic       aw_valid;
        axi_32_w_t  w;
        logic       w_valid;
        logic       b_ready;
        axi_32_ar_t ar;
        logic       ar_valid;
        logic       r_ready;
    } axi_32_req_t;

    typedef struct packed {
        logic      aw_ready;
        logic      ar_ready;
        logic      w_ready;
        logic      b_valid;
        axi_32_b_t b;
        logic      r_valid;
        axi_32_r_t r;
    } axi_32_resp_t;

endpackage

module obi_axi_bridge #(
    parameter type         axi_req_t       = obi_axi_pkg::axi_32_req_t,
    parameter type         axi_resp_t      = obi_axi_pkg::axi_32_resp_t,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output axi_req_t                axi_req_o,
    input  axi_resp_t               axi_resp_i,
    input  logic [ID_WIDTH-1:0]     axi_id_i
);

    localparam int unsigned c_cnt_w = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(MAX_OUTSTANDING - 1);
    localparam logic [2:0]         c_axi_size = 3'($clog2(DATA_WIDTH / 8));

    // Order FIFO and issue-side state
    logic [MAX_OUTSTANDING-1:0] order_q, order_d;
    logic [c_ptr_w-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [c_cnt_w-1:0]         cnt_q, cnt_d;
    logic                       aw_done_q, aw_done_d, w_done_q, w_done_d;
    // Registered OBI response
    logic                       rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       err_q, err_d;

    logic w_full, w_head, w_is_wr;
    logic w_ar_valid, w_aw_valid, w_w_valid;
    logic w_aw_hs, w_w_hs, w_rd_gnt, w_wr_gnt, w_gnt;
    logic w_r_ready, w_b_ready, w_r_hs, w_b_hs, w_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_full     = (cnt_q == c_cnt_full);
        w_head     = order_q[rptr_q];
        w_is_wr    = obi_req_i & obi_we_i;
        w_ar_valid = obi_req_i & ~obi_we_i & ~w_full;
        w_aw_valid = w_is_wr & ~w_full & ~aw_done_q;
        w_w_valid  = w_is_wr & ~w_full & ~w_done_q;
        w_aw_hs    = w_aw_valid & axi_resp_i.aw_ready;
        w_w_hs     = w_w_valid & axi_resp_i.w_ready;
        w_rd_gnt   = w_ar_valid & axi_resp_i.ar_ready;
        // A write is granted once both halves are done, either from an
        // earlier cycle (sticky flag) or by a handshake in this cycle.
        w_wr_gnt   = w_is_wr & (aw_done_q | w_aw_hs) & (w_done_q | w_w_hs);
        w_gnt      = w_rd_gnt | w_wr_gnt;
        // Only the channel matching the oldest outstanding request is
        // accepted; the other one is back-pressured to keep issue order.
        w_r_ready  = (cnt_q != '0) & ~w_head;
        w_b_ready  = (cnt_q != '0) & w_head;
        w_r_hs     = w_r_ready & axi_resp_i.r_valid;
        w_b_hs     = w_b_ready & axi_resp_i.b_valid;
        w_pop      = w_r_hs | w_b_hs;
    end

    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        order_d   = order_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;

        if (w_gnt) begin
            aw_done_d      = 1'b0;
            w_done_d       = 1'b0;
            order_d[wptr_q] = obi_we_i;
            wptr_d         = ptr_inc(wptr_q);
        end else begin
            if (w_aw_hs) aw_done_d = 1'b1;
            if (w_w_hs)  w_done_d  = 1'b1;
        end

        if (w_pop) rptr_d = ptr_inc(rptr_q);

        case ({w_gnt, w_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        rvalid_d = w_pop;
        rdata_d  = w_r_hs ? axi_resp_i.r.data : rdata_q;
`ifdef OBI_AXI_BRIDGE_ERR_EN
        // resp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY
        err_d = (w_r_hs & axi_resp_i.r.resp[1]) | (w_b_hs & axi_resp_i.b.resp[1]);
`else
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            order_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            order_q   <= order_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = axi_id_i;
        axi_req_o.aw.addr  = obi_addr_i;
        axi_req_o.aw.len   = '0;
        axi_req_o.aw.size  = c_axi_size;
        axi_req_o.aw.burst = 2'b01;
        axi_req_o.aw_valid = w_aw_valid;
        axi_req_o.w.data   = obi_wdata_i;
        axi_req_o.w.strb   = obi_be_i;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_w_valid;
        axi_req_o.ar.id    = axi_id_i;
        axi_req_o.ar.addr  = obi_addr_i;
        axi_req_o.ar.len   = '0;
        axi_req_o.ar.size  = c_axi_size;
        axi_req_o.ar.burst = 2'b01;
        axi_req_o.ar_valid = w_ar_valid;
        axi_req_o.r_ready  = w_r_ready;
        axi_req_o.b_ready  = w_b_ready;
    end

    assign obi_gnt_o    = w_gnt;
    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_err_o    = err_q;

    // Response fields the bridge has no use for (single-beat, static ID)
    logic w_unused_resp;
`ifdef OBI_AXI_BRIDGE_ERR_EN
    assign w_unused_resp = ^{axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.r.user,
                             axi_resp_i.b.id, axi_resp_i.b.user};
`else
    assign w_unused_resp = ^{axi_resp_i.r.id, axi_resp_i.r.last, axi_resp_i.r.user,
                             axi_resp_i.r.resp, axi_resp_i.b.id, axi_resp_i.b.user,
                             axi_resp_i.b.resp};
`endif

endmodule
`default_nettype wire

// File: tb/tb_obi_axi_bridge.sv
`default_nettype none
//==============================================================================
// Module   : tb_obi_axi_bridge
// Purpose  : Randomised OBI master and AXI slave around obi_axi_bridge with an
//            in-order scoreboard of expected OBI responses, plus directed
//            full-FIFO and mid-transaction reset sequences.
// Revision : 1.0 - initial release
//==============================================================================
module tb_obi_axi_bridge;
    import obi_axi_pkg::*;

    localparam int MAXO = 4;
`ifdef OBI_AXI_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        obi_req = 1'b0, obi_we = 1'b0;
    logic [3:0]  obi_be = '0;
    logic [31:0] obi_addr = '0, obi_wdata = '0;
    logic        obi_gnt, obi_rvalid, obi_err;
    logic [31:0] obi_rdata;
    axi_32_req_t  axi_req;
    axi_32_resp_t axi_resp = '0;
    logic [1:0]  axi_id = 2'b10;

    obi_axi_bridge #(
        .axi_req_t      (axi_32_req_t),
        .axi_resp_t     (axi_32_resp_t),
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .ID_WIDTH       (2),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .obi_req_i   (obi_req),
        .obi_gnt_o   (obi_gnt),
        .obi_we_i    (obi_we),
        .obi_be_i    (obi_be),
        .obi_addr_i  (obi_addr),
        .obi_wdata_i (obi_wdata),
        .obi_rvalid_o(obi_rvalid),
        .obi_rdata_o (obi_rdata),
        .obi_err_o   (obi_err),
        .axi_req_o   (axi_req),
        .axi_resp_i  (axi_resp),
        .axi_id_i    (axi_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Slave behaviour, defined purely by address
    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction
    function automatic logic err_of(input logic [31:0] a, input logic we);
        return we ? (a[7:4] == 4'h3) : (a[7:4] == 4'h5);
    endfunction
    function automatic logic [1:0] rsp_of(input logic [31:0] a, input logic we);
        return {err_of(a, we), 1'($urandom_range(0, 1))};
    endfunction

    // Reference model: responses expected in issue order
    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t        exp_q[$];
    bit          ord_q[$];
    int          hs_cyc_q[$];
    int          outst = 0;
    int          n_gnt = 0;
    int          cyc = 0;
    logic [31:0] last_rdata = '0;

    // Slave state
    logic [31:0] rq[$];
    logic [31:0] awq[$];
    int          w_cnt = 0;
    bit          gnt_seen = 0, r_taken = 0, b_taken = 0;

    // Stimulus controls
    bit en_master = 0, manual = 0, hold_resp = 0;
    int force_we = -1;
    int req_pct = 70, ar_pct = 70, aw_pct = 70, w_pct = 70, rsp_pct = 60;

    always @(posedge clk) cyc <= cyc + 1;

    // Driver: OBI master + AXI slave, inputs change 1 time unit after posedge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                axi_resp = '0;
                rq.delete();
                awq.delete();
                w_cnt = 0;
                r_taken = 0;
                b_taken = 0;
                gnt_seen = 0;
                if (!manual) obi_req = 1'b0;
                continue;
            end
            if (!manual) begin
                if (gnt_seen) obi_req = 1'b0;
                if (!obi_req && en_master && ($urandom_range(0, 99) < req_pct)) begin
                    obi_req   = 1'b1;
                    obi_we    = (force_we < 0) ? 1'($urandom_range(0, 1)) : 1'(force_we);
                    obi_addr  = $urandom & 32'h0000_0FFC;
                    obi_wdata = $urandom;
                    obi_be    = 4'($urandom_range(1, 15));
                end
            end
            gnt_seen = 0;
            axi_resp.ar_ready = ($urandom_range(0, 99) < ar_pct);
            axi_resp.aw_ready = ($urandom_range(0, 99) < aw_pct);
            axi_resp.w_ready  = ($urandom_range(0, 99) < w_pct);
            if (r_taken) begin
                axi_resp.r_valid = 1'b0;
                r_taken = 0;
            end
            if (!axi_resp.r_valid && rq.size() > 0 && !hold_resp &&
                ($urandom_range(0, 99) < rsp_pct)) begin
                logic [31:0] a;
                a = rq.pop_front();
                axi_resp.r_valid = 1'b1;
                axi_resp.r.data  = rd_data(a);
                axi_resp.r.resp  = rsp_of(a, 1'b0);
                axi_resp.r.id    = axi_id;
                axi_resp.r.last  = 1'b1;
            end
            if (b_taken) begin
                axi_resp.b_valid = 1'b0;
                b_taken = 0;
            end
            if (!axi_resp.b_valid && awq.size() > 0 && w_cnt > 0 && !hold_resp &&
                ($urandom_range(0, 99) < rsp_pct)) begin
                logic [31:0] a;
                a = awq.pop_front();
                w_cnt--;
                axi_resp.b_valid = 1'b1;
                axi_resp.b.resp  = rsp_of(a, 1'b1);
                axi_resp.b.id    = axi_id;
            end
        end
    end

    // Handshake bookkeeping and per-cycle protocol checks
    always @(negedge clk) begin
        if (rst_n) begin
            bit   full_m;
            exp_t e;
            full_m = (outst >= MAXO);
            check("ar_valid", axi_req.ar_valid, obi_req & ~obi_we & ~full_m);
            check("aw_w_gate", (axi_req.aw_valid | axi_req.w_valid) & ~(obi_req & obi_we & ~full_m), 1'b0);
            check("order_ready", {axi_req.r_ready, axi_req.b_ready},
                  (ord_q.size() == 0) ? 2'b00 : (ord_q[0] ? 2'b01 : 2'b10));
            if (obi_req && !obi_we) check("rd_gnt", obi_gnt, ~full_m & axi_resp.ar_ready);
            if (full_m) check("gnt_when_full", obi_gnt, 1'b0);

            if (axi_req.ar_valid && axi_resp.ar_ready) begin
                check("ar_fields", {axi_req.ar.addr, axi_req.ar.id, axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst},
                      {obi_addr, axi_id, 8'h00, 3'd2, 2'b01});
                rq.push_back(axi_req.ar.addr);
            end
            if (axi_req.aw_valid && axi_resp.aw_ready) begin
                check("aw_fields", {axi_req.aw.addr, axi_req.aw.id, axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst},
                      {obi_addr, axi_id, 8'h00, 3'd2, 2'b01});
                awq.push_back(axi_req.aw.addr);
            end
            if (axi_req.w_valid && axi_resp.w_ready) begin
                check("w_fields", {axi_req.w.data, axi_req.w.strb, axi_req.w.last}, {obi_wdata, obi_be, 1'b1});
                w_cnt++;
            end
            if (obi_gnt) begin
                e.we  = obi_we;
                e.err = ERR_EN && err_of(obi_addr, obi_we);
                if (!obi_we) last_rdata = rd_data(obi_addr);
                e.data = last_rdata;
                exp_q.push_back(e);
                ord_q.push_back(obi_we);
                outst++;
                n_gnt++;
                gnt_seen = 1;
            end
            if (axi_req.r_ready && axi_resp.r_valid) begin
                r_taken = 1;
                if (ord_q.size() > 0) void'(ord_q.pop_front());
                outst--;
                hs_cyc_q.push_back(cyc);
            end
            if (axi_req.b_ready && axi_resp.b_valid) begin
                b_taken = 1;
                if (ord_q.size() > 0) void'(ord_q.pop_front());
                outst--;
                hs_cyc_q.push_back(cyc);
            end
        end
    end

    // Response monitor: pops the scoreboard whenever OBI sees a response
    always @(negedge clk) begin
        if (rst_n && obi_rvalid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rvalid: got rvalid=1, required no response pending");
            end else begin
                exp_t e;
                int   c;
                e = exp_q.pop_front();
                c = (hs_cyc_q.size() > 0) ? hs_cyc_q.pop_front() : -10;
                check(e.we ? "wr_rdata" : "rd_rdata", obi_rdata, e.data);
                check(e.we ? "wr_err" : "rd_err", obi_err, e.err);
                check("rvalid_latency", 64'(cyc), 64'(c + 1));
            end
        end
    end

    task automatic drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !obi_req) break;
        end
        n_cmp++;
        if (exp_q.size() != 0 || obi_req) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d responses pending, required 0", exp_q.size());
        end
    endtask

    task automatic obi_issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bit got;
        got = 0;
        @(posedge clk);
        #2;
        obi_req = 1'b1; obi_we = we; obi_addr = a; obi_wdata = d; obi_be = be;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = obi_gnt;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL manual_grant: got no grant, required grant for addr %0h", a);
        end
        @(posedge clk);
        #2;
        obi_req = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        ord_q.delete();
        hs_cyc_q.delete();
        outst = 0;
        last_rdata = '0;
    endtask

    initial begin
        int g0;
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {obi_gnt, obi_rvalid, obi_err, obi_rdata, axi_req.ar_valid,
                                axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready, axi_req.b_ready}, 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Randomised traffic with varying back-pressure
        en_master = 1;
        for (int k = 0; k < 15; k++) begin
            req_pct = $urandom_range(30, 100);
            ar_pct  = $urandom_range(20, 100);
            aw_pct  = $urandom_range(20, 100);
            w_pct   = $urandom_range(20, 100);
            rsp_pct = $urandom_range(20, 100);
            repeat (100) @(posedge clk);
        end
        en_master = 0;
        drain();

        // Full order FIFO: back-to-back reads with responses withheld
        hold_resp = 1; force_we = 0; req_pct = 100; ar_pct = 100; rsp_pct = 100;
        g0 = n_gnt;
        en_master = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check("full_grants", 64'(n_gnt - g0), 64'(MAXO));
        check("fifth_blocked", {obi_req, obi_gnt}, 2'b10);
        en_master = 0;
        hold_resp = 0;
        force_we = -1;
        drain();

        // Reset with two reads outstanding and the write's AW already done
        manual = 1; hold_resp = 1; ar_pct = 100; aw_pct = 100; w_pct = 0;
        obi_issue(1'b0, 32'h0000_1000, 32'h0, 4'hF);
        obi_issue(1'b0, 32'h0000_1004, 32'h0, 4'hF);
        @(posedge clk);
        #2;
        obi_req = 1'b1; obi_we = 1'b1; obi_addr = 32'h0000_2000; obi_wdata = 32'h1234_5678; obi_be = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("aw_sticky", {axi_req.aw_valid, axi_req.w_valid, obi_gnt}, 3'b010);
        #2;
        rst_n = 1'b0;
        obi_req = 1'b0;
        #1;
        check("async_reset", {obi_gnt, obi_rvalid, obi_err, obi_rdata, axi_req.ar_valid,
                              axi_req.aw_valid, axi_req.w_valid, axi_req.r_ready, axi_req.b_ready}, 64'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        hold_resp = 0; w_pct = 100; aw_pct = 100;
        @(posedge clk);
        #2;
        obi_req = 1'b1; obi_we = 1'b1; obi_addr = 32'h0000_3000; obi_wdata = 32'hCAFE_F00D; obi_be = 4'hF;
        @(negedge clk);
        #1;
        check("post_reset_write", {axi_req.aw_valid, axi_req.w_valid, obi_gnt}, 3'b111);
        @(posedge clk);
        #2;
        obi_req = 1'b0;
        manual = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/obi_axi_bridge.md
Name: obi_axi_bridge

Overview:
- Registered OBI-to-AXI4 manager bridge for the core's instruction and data ports in the FPGA subsystem; drives an axi_req_t/axi_resp_t pair.
- Handles AW and W handshakes independently and tracks up to MAX_OUTSTANDING transactions in an order FIFO.
- Returns R and B responses to OBI strictly in issue order.
- Propagates AXI SLVERR/DECERR to OBI err.

Parameters:
- axi_req_t, axi_32_req_t, AXI request struct type
- axi_resp_t, axi_32_resp_t, AXI response struct type
- DATA_WIDTH, 32, OBI/AXI data width; power of two, 8..1024
- ADDR_WIDTH, 32, address width
- ID_WIDTH, 2, AXI ID width
- MAX_OUTSTANDING, 4, order-FIFO depth; power of two, at least 1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_req_i  in  1  OBI request
- obi_gnt_o  out  1  OBI grant
- obi_we_i  in  1  write enable
- obi_be_i  in  DATA_WIDTH/8  byte enables
- obi_addr_i  in  ADDR_WIDTH  address
- obi_wdata_i  in  DATA_WIDTH  write data
- obi_rvalid_o  out  1  response valid, for reads and writes
- obi_rdata_o  out  DATA_WIDTH  read data
- obi_err_o  out  1  response error
- axi_req_o  out  axi_req_t  AXI request channels
- axi_resp_i  in  axi_resp_t  AXI response channels
- axi_id_i  in  ID_WIDTH  static AXI ID for AW and AR

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: all state cleared.
  - obi_gnt_o=0, obi_rvalid_o=0, obi_rdata_o=0, obi_err_o=0.
  - All AXI valid signals 0; b_ready and r_ready 0.
- Static AXI fields:
  - len=0, size=log2(DATA_WIDTH/8), burst=INCR (2'b01), w.last=1.
  - cache, prot, qos, region, atop, user all zero.
- Order FIFO:
  - Depth MAX_OUTSTANDING; each entry holds 1 bit (0=read, 1=write).
  - cnt has width $clog2(MAX_OUTSTANDING)+1; read/write pointers wrap modulo depth.
  - full = (cnt==MAX_OUTSTANDING).
- Read issue:
  - ar_valid = obi_req_i & ~obi_we_i & ~full.
  - obi_gnt_o = ar_valid & ar_ready, combinational.
  - Push 0 on grant.
- Write issue:
  - Per-request sticky flags aw_done and w_done.
  - aw_valid = obi_req_i & obi_we_i & ~full & ~aw_done.
  - w_valid = obi_req_i & obi_we_i & ~full & ~w_done.
  - A flag is set when its handshake completes without a grant in the same cycle.
  - obi_gnt_o = (aw_done | aw_valid&aw_ready) & (w_done | w_valid&w_ready).
  - On grant: push 1 and clear both flags.
  - AW before W, W before AW, and both in the same cycle are all legal.
- OBI stability: address, we, be and wdata are stable until grant (OBI rule). The bridge does not latch them.
- Response ordering:
  - r_ready = (cnt!=0) & head==0.
  - b_ready = (cnt!=0) & head==1.
  - The non-head channel is back-pressured.
  - A handshake pops the FIFO.
- Response output:
  - Registered: one cycle after the R or B handshake, obi_rvalid_o=1 for exactly one cycle.
  - On R: obi_rdata_o = r.data. On B: obi_rdata_o holds its previous value.
  - obi_err_o = resp[1] of the accepted beat.
- Simultaneous push and pop: cnt is unchanged. A push is allowed when full only if a pop happens the same cycle? No: full blocks issue; a pop in the same cycle does not unblock until the next cycle.
- Minimum latency: grant in cycle N, AXI response in N+1, obi_rvalid_o in N+2.
- Reset mid-transaction: flags, FIFO and outputs clear immediately. AXI responses still in flight afterwards are the system's responsibility; the bridge is reset together with the interconnect.

Optional Feature:
- Macro: OBI_AXI_BRIDGE_ERR_EN.
- Defined: obi_err_o reflects SLVERR/DECERR as described in Behaviour.
- Undefined: obi_err_o is tied to 0 and resp bits are ignored; read data is still returned.

Test Plan:
- Single read, addr=0x0000_1000, slave returns 0xDEADBEEF after 1 cycle -> ar_valid for 1 cycle, gnt in same cycle, obi_rvalid_o=1 with rdata=0xDEADBEEF two cycles after grant, err=0.
- Write with W accepted 3 cycles before AW (addr=0x2000, wdata=0x12345678, be=4'b0011) -> w_valid drops after its handshake, gnt only in the AW handshake cycle, one obi_rvalid_o after B=OKAY.
- MAX_OUTSTANDING=4: five back-to-back reads with responses withheld -> four grants, fifth gnt=0 until the first R handshake, then granted the following cycle.
- Interleaved write then read (IDs equal); slave presents R before B -> r_ready=0 until B accepted; OBI sees the write response, then the read response.
- Read returning SLVERR (resp=2'b10) -> obi_err_o=1 with the rvalid pulse when macro defined; obi_err_o=0 when macro undefined.
- Assert rst_ni low while 2 reads are outstanding and aw_done=1 -> all outputs 0 asynchronously, cnt=0; after release, a new write issues both AW and W.
